// File: rtl/i2c_target.sv
// I2C target: 2-FF synchronised SCL/SDA, START/STOP detect, fixed 7-bit address, open-drain SDA, no clock stretching.
// Bus events seen 3 clk after the pins; SDA updates <=4 clk after SCL fall; no backpressure, tx_data must be ready when tx_req pulses.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_scl_s3;
    logic       r_sda_s1, r_sda_s2, r_sda_s3;
    logic [7:0] r_sreg, w_sreg_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_ph, w_ph_nxt;
    logic       r_drv_low, w_drv_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_busy, w_busy_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       w_tx_req;
    logic       w_rise, w_fall, w_start, w_stop;

    assign sda = r_drv_low ? 1'b0 : 1'bz;

    assign w_rise  =  r_scl_s2 & ~r_scl_s3;
    assign w_fall  = ~r_scl_s2 &  r_scl_s3;
    assign w_start =  r_scl_s2 &  r_sda_s3 & ~r_sda_s2;
    assign w_stop  =  r_scl_s2 & ~r_sda_s3 &  r_sda_s2;

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = w_tx_req;
    assign rw       = r_rw;
    assign busy     = r_busy;

    // Synchronisers reset to the idle-bus level so release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_s3 <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_s3 <= 1'b1;
        end else begin
            r_scl_s1 <= scl; r_scl_s2 <= r_scl_s1; r_scl_s3 <= r_scl_s2;
            r_sda_s1 <= sda; r_sda_s2 <= r_sda_s1; r_sda_s3 <= r_sda_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sreg     <= 8'h00;
            r_cnt      <= 3'd0;
            r_ph       <= 1'b0;
            r_drv_low  <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sreg     <= w_sreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ph       <= w_ph_nxt;
            r_drv_low  <= w_drv_nxt;
            r_rw       <= w_rw_nxt;
            r_busy     <= w_busy_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    // r_ph splits each ACK state into its two halves (drive / release, or ACK seen / reload).
    always_comb begin
        w_state_nxt    = r_state;
        w_sreg_nxt     = r_sreg;
        w_cnt_nxt      = r_cnt;
        w_ph_nxt       = r_ph;
        w_drv_nxt      = r_drv_low;
        w_rw_nxt       = r_rw;
        w_busy_nxt     = r_busy;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req       = 1'b0;
        if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = 3'd0;
            w_ph_nxt    = 1'b0;
            w_drv_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_drv_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: if (w_rise) begin
                    w_sreg_nxt = {r_sreg[6:0], r_sda_s2};
                    w_cnt_nxt  = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = S_ADDR_ACK;
                        w_ph_nxt    = 1'b0;
                    end
                end
                S_ADDR_ACK: if (w_fall) begin
                    if (!r_ph) begin
                        if (r_sreg[7:1] == ADDR) begin
                            w_drv_nxt  = 1'b1;
                            w_rw_nxt   = r_sreg[0];
                            w_busy_nxt = 1'b1;
                            w_ph_nxt   = 1'b1;
                        end else begin
                            w_drv_nxt   = 1'b0;
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end else begin
                        w_ph_nxt  = 1'b0;
                        w_cnt_nxt = 3'd0;
                        if (!r_rw) begin
                            w_drv_nxt   = 1'b0;
                            w_state_nxt = S_WR_BYTE;
                        end else begin
                            w_tx_req    = 1'b1;
                            w_sreg_nxt  = tx_data;
                            w_drv_nxt   = ~tx_data[7];
                            w_state_nxt = S_RD_BYTE;
                        end
                    end
                end
                S_WR_BYTE: if (w_rise) begin
                    w_sreg_nxt = {r_sreg[6:0], r_sda_s2};
                    w_cnt_nxt  = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rx_data_nxt  = {r_sreg[6:0], r_sda_s2};
                        w_rx_valid_nxt = 1'b1;
                        w_state_nxt    = S_WR_ACK;
                        w_ph_nxt       = 1'b0;
                    end
                end
                S_WR_ACK: if (w_fall) begin
                    if (!r_ph) begin
                        w_drv_nxt = 1'b1;
                        w_ph_nxt  = 1'b1;
                    end else begin
                        w_drv_nxt   = 1'b0;
                        w_ph_nxt    = 1'b0;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_WR_BYTE;
                    end
                end
                S_RD_BYTE: if (w_fall) begin
                    if (r_cnt == 3'd7) begin
                        w_drv_nxt   = 1'b0;
                        w_ph_nxt    = 1'b0;
                        w_state_nxt = S_RD_ACK;
                    end else begin
                        w_sreg_nxt = {r_sreg[6:0], 1'b0};
                        w_drv_nxt  = ~r_sreg[6];
                        w_cnt_nxt  = r_cnt + 3'd1;
                    end
                end
                S_RD_ACK: begin
                    if (!r_ph && w_rise) begin
                        if (!r_sda_s2) begin
                            w_ph_nxt = 1'b1;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end else if (r_ph && w_fall) begin
                        w_tx_req    = 1'b1;
                        w_sreg_nxt  = tx_data;
                        w_drv_nxt   = ~tx_data[7];
                        w_cnt_nxt   = 3'd0;
                        w_ph_nxt    = 1'b0;
                        w_state_nxt = S_RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master driving random transfers, checked against a transaction-level model.
// The model predicts ACK bits, received bytes, read-back bytes and request/strobe counts per transfer.
module tb_i2c_target;

    localparam logic [6:0] TADDR = 7'h50;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       rw;
    logic       busy;

    logic [7:0] tx_bytes [0:63];
    logic [7:0] dat [0:3];
    int         tx_hi = 0;
    int         rx_hi = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_tx = 0;
    int         exp_rx = 0;
    logic       exp_rw = 1'b0;
    logic [7:0] exp_rxd = 8'h00;

    always #5 clk = ~clk;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    assign tx_data = tx_bytes[tx_hi[5:0]];

    always @(posedge clk) begin
        if (tx_req)   tx_hi <= tx_hi + 1;
        if (rx_valid) rx_hi <= rx_hi + 1;
    end

    i2c_target #(.ADDR(TADDR)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .rw(rw), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; clks(Q);
        scl = 1'b1; clks(2 * Q);
        scl = 1'b0; clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; clks(Q);
        scl = 1'b1; clks(Q);
        b = sda;    clks(Q);
        scl = 1'b0; clks(Q);
    endtask

    // Also serves as repeated START when SCL is low on entry.
    task automatic start_cond();
        m_low = 1'b0; clks(Q);
        scl = 1'b1;   clks(Q);
        m_low = 1'b1; clks(Q);
        scl = 1'b0;   clks(Q);
    endtask

    task automatic stop_cond();
        m_low = 1'b1; clks(Q);
        scl = 1'b1;   clks(Q);
        m_low = 1'b0; clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic nack);
        for (int i = 7; i >= 0; i--) read_bit(v[i]);
        write_bit(nack);
    endtask

    // Transfer with model: a matched target ACKs, requests one byte at address ACK and after each master ACK.
    task automatic xfer(input logic [6:0] a, input logic r, input int n, input logic do_stop);
        logic       m;
        logic       ack;
        logic [7:0] b;
        m = (a == TADDR);
        start_cond();
        chk("busy_start", busy, 0);
        send_byte({a, r}, ack);
        chk("addr_ack", ack, !m);
        chk("busy_addr", busy, m);
        if (m) exp_rw = r;
        chk("rw", rw, exp_rw);
        if (m && r) exp_tx++;
        chk("tx_cnt_addr", tx_hi, exp_tx);
        for (int i = 0; i < n; i++) begin
            if (!r) begin
                send_byte(dat[i], ack);
                chk("wr_ack", ack, !m);
                if (m) begin
                    exp_rx++;
                    exp_rxd = dat[i];
                end
                chk("rx_cnt", rx_hi, exp_rx);
                chk("rx_data", rx_data, exp_rxd);
            end else begin
                recv_byte(b, i == n - 1);
                chk("rd_byte", b, m ? tx_bytes[exp_tx - 1] : 8'hFF);
                if (m && i != n - 1) exp_tx++;
                chk("tx_cnt", tx_hi, exp_tx);
            end
        end
        chk("busy_end", busy, m && !r);
        if (do_stop) begin
            stop_cond();
            chk("busy_stop", busy, 0);
            chk("sda_idle", sda, 1);
        end
    endtask

    initial begin
        logic       ack;
        logic       all_one;
        logic       b;
        logic       pend;
        logic       r;
        logic [6:0] a;
        int         n;

        for (int i = 0; i < 64; i++) tx_bytes[i] = 8'($urandom);
        tx_bytes[0] = 8'h3C;
        tx_bytes[1] = 8'hC3;

        rst = 1'b0; scl = 1'b1; m_low = 1'b0;
        clks(4);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_rw", rw, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sda", sda, 1);
        rst = 1'b1;
        clks(4);

        dat[0] = 8'hA5; xfer(7'h50, 1'b0, 1, 1'b1);
        dat[0] = 8'h11; xfer(7'h51, 1'b0, 1, 1'b1);
        xfer(7'h50, 1'b1, 2, 1'b1);
        dat[0] = 8'h5A; xfer(7'h50, 1'b0, 1, 1'b0);
        xfer(7'h50, 1'b1, 1, 1'b1);
        chk("rx_hold", rx_data, 8'h5A);

        start_cond();
        send_byte(8'hA0, ack);
        chk("mid_addr_ack", ack, 0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        stop_cond();
        chk("mid_rx_cnt", rx_hi, exp_rx);
        chk("mid_busy", busy, 0);
        chk("mid_sda", sda, 1);
        dat[0] = 8'h0F; xfer(7'h50, 1'b0, 1, 1'b1);

        start_cond();
        for (int i = 7; i >= 0; i--) write_bit(i == 5 || i == 7);
        m_low = 1'b0;
        clks(1);
        chk("ack_held", sda, 0);
        rst = 1'b0;
        #1;
        chk("rstack_sda", sda, 1);
        chk("rstack_busy", busy, 0);
        chk("rstack_rw", rw, 0);
        chk("rstack_rx_data", rx_data, 8'h00);
        chk("rstack_rx_valid", rx_valid, 0);
        chk("rstack_tx_req", tx_req, 0);
        exp_rw = 1'b0;
        exp_rxd = 8'h00;
        clks(2);
        rst = 1'b1;
        scl = 1'b1; clks(2 * Q);
        scl = 1'b0; clks(Q);
        all_one = 1'b1;
        for (int i = 0; i < 9; i++) begin
            read_bit(b);
            all_one = all_one & b & ~busy;
        end
        chk("ignore_bus", all_one, 1);
        stop_cond();
        chk("ignore_rx_cnt", rx_hi, exp_rx);

        pend = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) != 0) begin
                a = TADDR;
            end else begin
                a = 7'($urandom);
                if (a == TADDR) a = a ^ 7'h01;
            end
            r = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            pend = (t == 15) || ($urandom_range(0, 3) != 0);
            xfer(a, r, n, pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
